// File: rtl/mem_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4-Lite arbiter.
// One outstanding transaction, round-robin grant on ties.
module mem_arbiter #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ifu_arvalid,
   output logic                    ifu_arready,
   input  logic [ADDR_LEN-1:0]     ifu_araddr,
   output logic                    ifu_rvalid,
   input  logic                    ifu_rready,
   output logic [DATA_LEN-1:0]     ifu_rdata,
   output logic [1:0]              ifu_rresp,
   input  logic                    lsu_arvalid,
   output logic                    lsu_arready,
   input  logic [ADDR_LEN-1:0]     lsu_araddr,
   output logic                    lsu_rvalid,
   input  logic                    lsu_rready,
   output logic [DATA_LEN-1:0]     lsu_rdata,
   output logic [1:0]              lsu_rresp,
   input  logic                    lsu_awvalid,
   output logic                    lsu_awready,
   input  logic [ADDR_LEN-1:0]     lsu_awaddr,
   input  logic                    lsu_wvalid,
   output logic                    lsu_wready,
   input  logic [DATA_LEN-1:0]     lsu_wdata,
   input  logic [DATA_LEN/8-1:0]   lsu_wstrb,
   output logic                    lsu_bvalid,
   input  logic                    lsu_bready,
   output logic [1:0]              lsu_bresp,
   output logic                    mem_arvalid,
   input  logic                    mem_arready,
   output logic [ADDR_LEN-1:0]     mem_araddr,
   input  logic                    mem_rvalid,
   output logic                    mem_rready,
   input  logic [DATA_LEN-1:0]     mem_rdata,
   input  logic [1:0]              mem_rresp,
   output logic                    mem_awvalid,
   input  logic                    mem_awready,
   output logic [ADDR_LEN-1:0]     mem_awaddr,
   output logic                    mem_wvalid,
   input  logic                    mem_wready,
   output logic [DATA_LEN-1:0]     mem_wdata,
   output logic [DATA_LEN/8-1:0]   mem_wstrb,
   input  logic                    mem_bvalid,
   output logic                    mem_bready,
   input  logic [1:0]              mem_bresp,
   output logic [1:0]              owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      IFU_RD = 2'b01,
      LSU_RD = 2'b10,
      LSU_WR = 2'b11
   } state_t;

   state_t state;
   logic   last_lsu;
   logic   ar_done;
   logic   aw_done;
   logic   w_done;

   logic   ifu_req;
   logic   lsu_wr_req;
   logic   lsu_req;
   logic   grant_lsu;

   assign ifu_req    = ifu_arvalid;
   assign lsu_wr_req = lsu_awvalid & lsu_wvalid;
   assign lsu_req    = lsu_wr_req | lsu_arvalid;
   // LSU wins when alone or when the IFU was the last one served
   assign grant_lsu  = lsu_req & (~ifu_req | ~last_lsu);

   // state itself is the registered grant code
   assign owner = state;

   // grant, handshake tracking and return to idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         last_lsu <= 1'b0;
         ar_done  <= 1'b0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ifu_req | lsu_req) begin
                  ar_done <= 1'b0;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  if (grant_lsu) begin
                     last_lsu <= 1'b1;
                     state    <= lsu_wr_req ? LSU_WR : LSU_RD;
                  end else begin
                     last_lsu <= 1'b0;
                     state    <= IFU_RD;
                  end
               end
            end
            IFU_RD, LSU_RD: begin
               if (mem_arvalid & mem_arready)
                  ar_done <= 1'b1;
               if (mem_rvalid & mem_rready)
                  state <= IDLE;
            end
            LSU_WR: begin
               if (mem_awvalid & mem_awready)
                  aw_done <= 1'b1;
               if (mem_wvalid & mem_wready)
                  w_done <= 1'b1;
               if (mem_bvalid & mem_bready)
                  state <= IDLE;
            end
         endcase
      end
   end

   // route the owner's channels; everything else is held at zero
   always_comb begin
      ifu_arready = 1'b0;
      ifu_rvalid  = 1'b0;
      ifu_rdata   = '0;
      ifu_rresp   = '0;
      lsu_arready = 1'b0;
      lsu_rvalid  = 1'b0;
      lsu_rdata   = '0;
      lsu_rresp   = '0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bvalid  = 1'b0;
      lsu_bresp   = '0;
      mem_arvalid = 1'b0;
      mem_araddr  = '0;
      mem_rready  = 1'b0;
      mem_awvalid = 1'b0;
      mem_awaddr  = '0;
      mem_wvalid  = 1'b0;
      mem_wdata   = '0;
      mem_wstrb   = '0;
      mem_bready  = 1'b0;
      unique case (state)
         IDLE: begin
         end
         IFU_RD: begin
            mem_arvalid = ifu_arvalid & ~ar_done;
            mem_araddr  = ifu_araddr;
            ifu_arready = mem_arready & ~ar_done;
            ifu_rvalid  = mem_rvalid;
            ifu_rdata   = mem_rdata;
            ifu_rresp   = mem_rresp;
            mem_rready  = ifu_rready;
         end
         LSU_RD: begin
            mem_arvalid = lsu_arvalid & ~ar_done;
            mem_araddr  = lsu_araddr;
            lsu_arready = mem_arready & ~ar_done;
            lsu_rvalid  = mem_rvalid;
            lsu_rdata   = mem_rdata;
            lsu_rresp   = mem_rresp;
            mem_rready  = lsu_rready;
         end
         LSU_WR: begin
            mem_awvalid = lsu_awvalid & ~aw_done;
            mem_awaddr  = lsu_awaddr;
            lsu_awready = mem_awready & ~aw_done;
            mem_wvalid  = lsu_wvalid & ~w_done;
            mem_wdata   = lsu_wdata;
            mem_wstrb   = lsu_wstrb;
            lsu_wready  = mem_wready & ~w_done;
            lsu_bvalid  = mem_bvalid;
            lsu_bresp   = mem_bresp;
            mem_bready  = lsu_bready;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, pass-through,
// done-flag gating and asynchronous reset abort.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_arvalid, ifu_arready;
   logic [31:0] ifu_araddr;
   logic        ifu_rvalid, ifu_rready;
   logic [31:0] ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic        lsu_arvalid, lsu_arready;
   logic [31:0] lsu_araddr;
   logic        lsu_rvalid, lsu_rready;
   logic [31:0] lsu_rdata;
   logic [1:0]  lsu_rresp;
   logic        lsu_awvalid, lsu_awready;
   logic [31:0] lsu_awaddr;
   logic        lsu_wvalid, lsu_wready;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wstrb;
   logic        lsu_bvalid, lsu_bready;
   logic [1:0]  lsu_bresp;
   logic        mem_arvalid, mem_arready;
   logic [31:0] mem_araddr;
   logic        mem_rvalid, mem_rready;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_rresp;
   logic        mem_awvalid, mem_awready;
   logic [31:0] mem_awaddr;
   logic        mem_wvalid, mem_wready;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_bvalid, mem_bready;
   logic [1:0]  mem_bresp;
   logic [1:0]  owner;

   int n_chk = 0;
   int n_err = 0;
   int aw_hs = 0;
   int w_hs  = 0;
   int aw0, w0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_araddr(ifu_araddr),
      .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
      .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
      .lsu_araddr(lsu_araddr),
      .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
      .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
      .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
      .lsu_awaddr(lsu_awaddr),
      .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
      .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
      .lsu_bresp(lsu_bresp),
      .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
      .mem_araddr(mem_araddr),
      .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
      .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
      .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
      .mem_awaddr(mem_awaddr),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
      .mem_bresp(mem_bresp),
      .owner(owner)
   );

   always #5 clk = ~clk;

   // count slave-side address/data handshakes
   always @(posedge clk) begin
      if (mem_awvalid & mem_awready) aw_hs <= aw_hs + 1;
      if (mem_wvalid & mem_wready)   w_hs  <= w_hs + 1;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // serve a read whose grant state was just entered
   task automatic serve_rd(input logic [1:0]  own,
                           input logic [31:0] addr,
                           input logic [31:0] data,
                           input int          wt);
      check("rd_owner", 32'(owner), 32'(own));
      check("rd_arvalid", 32'(mem_arvalid), 1);
      check("rd_araddr", mem_araddr, addr);
      mem_arready = 1'b1;
      #1;
      check("rd_arready", (own == 2'd1) ?
            32'(ifu_arready) : 32'(lsu_arready), 1);
      check("rd_other_ardy", (own == 2'd1) ?
            32'(lsu_arready) : 32'(ifu_arready), 0);
      tick();
      mem_arready = 1'b0;
      if (own == 2'd1) ifu_arvalid = 1'b0;
      else lsu_arvalid = 1'b0;
      repeat (wt) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      mem_rresp  = 2'd0;
      #1;
      check("rd_rvalid", (own == 2'd1) ?
            32'(ifu_rvalid) : 32'(lsu_rvalid), 1);
      check("rd_rdata", (own == 2'd1) ?
            ifu_rdata : lsu_rdata, data);
      check("rd_other_rv", (own == 2'd1) ?
            32'(lsu_rvalid) : 32'(ifu_rvalid), 0);
      check("rd_rready", 32'(mem_rready), 1);
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      #1;
      check("rd_idle", 32'(owner), 0);
   endtask

   initial begin
      rst = 1'b1;
      ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 1;
      lsu_arvalid = 0; lsu_araddr = '0; lsu_rready = 1;
      lsu_awvalid = 0; lsu_awaddr = '0;
      lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0;
      lsu_bready = 1;
      mem_arready = 0; mem_rvalid = 0;
      mem_rdata = '0; mem_rresp = '0;
      mem_awready = 0; mem_wready = 0;
      mem_bvalid = 0; mem_bresp = '0;
      #1;
      check("rst_owner", 32'(owner), 0);
      check("rst_arvalid", 32'(mem_arvalid), 0);
      check("rst_awvalid", 32'(mem_awvalid), 0);
      check("rst_bvalid", 32'(lsu_bvalid), 0);
      tick();
      tick();
      rst = 1'b0;

      // IFU read, slave answers two cycles after AR
      ifu_araddr  = 32'h8000_0000;
      ifu_arvalid = 1'b1;
      #1;
      check("t1_idle", 32'(owner), 0);
      check("t1_idle_ardy", 32'(ifu_arready), 0);
      tick();
      serve_rd(2'd1, 32'h8000_0000, 32'h0000_0413, 2);

      // tie after reset: LSU, then IFU, then LSU
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ifu_araddr  = 32'h100;
      ifu_arvalid = 1'b1;
      lsu_araddr  = 32'h200;
      lsu_arvalid = 1'b1;
      tick();
      serve_rd(2'd2, 32'h200, 32'h11, 0);
      lsu_arvalid = 1'b1;
      tick();
      serve_rd(2'd1, 32'h100, 32'h22, 0);
      tick();
      serve_rd(2'd2, 32'h200, 32'h33, 0);

      // LSU write, W accepted two cycles before AW
      aw0 = aw_hs;
      w0  = w_hs;
      lsu_awaddr  = 32'h8000_0010;
      lsu_wdata   = 32'hDEAD_BEEF;
      lsu_wstrb   = 4'hF;
      lsu_awvalid = 1'b1;
      lsu_wvalid  = 1'b1;
      mem_wready  = 1'b1;
      #1;
      check("t3_idle_wv", 32'(mem_wvalid), 0);
      tick();
      check("t3_owner", 32'(owner), 3);
      check("t3_awaddr", mem_awaddr, 32'h8000_0010);
      check("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("t3_wstrb", 32'(mem_wstrb), 32'hF);
      check("t3_wready", 32'(lsu_wready), 1);
      check("t3_awready0", 32'(lsu_awready), 0);
      check("t3_no_ar", 32'(mem_arvalid), 0);
      tick();
      check("t3_wv_done", 32'(mem_wvalid), 0);
      check("t3_wr_done", 32'(lsu_wready), 0);
      tick();
      mem_awready = 1'b1;
      #1;
      check("t3_awready", 32'(lsu_awready), 1);
      tick();
      check("t3_awv_done", 32'(mem_awvalid), 0);
      lsu_awvalid = 1'b0;
      lsu_wvalid  = 1'b0;
      mem_bvalid  = 1'b1;
      mem_bresp   = 2'd0;
      #1;
      check("t3_bvalid", 32'(lsu_bvalid), 1);
      check("t3_bresp", 32'(lsu_bresp), 0);
      check("t3_bready", 32'(mem_bready), 1);
      tick();
      mem_bvalid  = 1'b0;
      mem_awready = 1'b0;
      mem_wready  = 1'b0;
      #1;
      check("t3_idle", 32'(owner), 0);
      check("t3_aw_cnt", 32'(aw_hs - aw0), 1);
      check("t3_w_cnt", 32'(w_hs - w0), 1);

      // LSU write and read together: write first
      lsu_awaddr  = 32'h404;
      lsu_araddr  = 32'h400;
      lsu_awvalid = 1'b1;
      lsu_wvalid  = 1'b1;
      lsu_arvalid = 1'b1;
      tick();
      check("t4_owner", 32'(owner), 3);
      check("t4_no_ar", 32'(mem_arvalid), 0);
      mem_awready = 1'b1;
      mem_wready  = 1'b1;
      tick();
      mem_awready = 1'b0;
      mem_wready  = 1'b0;
      lsu_awvalid = 1'b0;
      lsu_wvalid  = 1'b0;
      mem_bvalid  = 1'b1;
      tick();
      mem_bvalid = 1'b0;
      #1;
      check("t4_idle", 32'(owner), 0);
      tick();
      serve_rd(2'd2, 32'h400, 32'h44, 1);

      // LSU request while IFU read stalls on R
      ifu_araddr  = 32'h500;
      ifu_arvalid = 1'b1;
      tick();
      check("t5_owner", 32'(owner), 1);
      mem_arready = 1'b1;
      tick();
      ifu_arvalid = 1'b0;
      lsu_araddr  = 32'h600;
      lsu_arvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t5_lsu_ardy", 32'(lsu_arready), 0);
         check("t5_araddr", mem_araddr, 32'h500);
         check("t5_hold", 32'(owner), 1);
         tick();
      end
      mem_arready = 1'b0;
      mem_rvalid  = 1'b1;
      mem_rdata   = 32'h55;
      #1;
      check("t5_ifu_rv", 32'(ifu_rvalid), 1);
      check("t5_lsu_rv", 32'(lsu_rvalid), 0);
      tick();
      mem_rvalid = 1'b0;
      #1;
      check("t5_idle", 32'(owner), 0);
      tick();
      serve_rd(2'd2, 32'h600, 32'h66, 0);

      // reset during a write with W outstanding
      lsu_awaddr  = 32'h700;
      lsu_awvalid = 1'b1;
      lsu_wvalid  = 1'b1;
      tick();
      check("t6_owner", 32'(owner), 3);
      mem_awready = 1'b1;
      tick();
      mem_awready = 1'b0;
      #1;
      check("t6_w_pend", 32'(mem_wvalid), 1);
      check("t6_aw_done", 32'(mem_awvalid), 0);
      rst = 1'b1;
      #1;
      check("t6_rst_own", 32'(owner), 0);
      check("t6_rst_wv", 32'(mem_wvalid), 0);
      lsu_awvalid = 1'b0;
      lsu_wvalid  = 1'b0;
      tick();
      rst = 1'b0;
      mem_bvalid = 1'b1;
      #1;
      check("t6_bready", 32'(mem_bready), 0);
      check("t6_bvalid", 32'(lsu_bvalid), 0);
      tick();
      check("t6_idle", 32'(owner), 0);
      mem_bvalid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
